// File: rtl/mini_aes_key_schedule.sv
// Mini-AES round-key generator.
// Builds each round key one nibble per cycle in a working register and publishes it
// atomically on round_key when the round completes.
//
// Ports:
//   clk                 - rising-edge clock
//   nrst                - asynchronous active-low reset
//   key_in[15:0]        - cipher key (w0=[15:12] .. w3=[3:0])
//   load_key_init       - synchronous key load / round restart (beats the FSM)
//   load_key_generation - level request for the next round key, held until done
//   round_key[15:0]     - current round key (K0 after init, Ki after round i)
//   key_generation_done - registered, high while the FSM sits in DONE
//   final_round         - registered, high when round_num == ROUNDS
//   round_num[3:0]      - number of completed rounds (saturates at ROUNDS)
module mini_aes_key_schedule #(
  parameter int unsigned ROUNDS = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] key_in,
  input  logic        load_key_init,
  input  logic        load_key_generation,
  output logic [15:0] round_key,
  output logic        key_generation_done,
  output logic        final_round,
  output logic [3:0]  round_num
);

  localparam logic [3:0] RoundsN = 4'(ROUNDS);

  typedef enum logic [2:0] {
    StIdle,
    StSub,
    StW0,
    StW1,
    StW2,
    StW3,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] key_q, key_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  t_q, t_d;
  logic [3:0]  rcon_q, rcon_d;
  logic [3:0]  rnum_q, rnum_d;
  logic        done_q;
  logic        final_q;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    s = 4'h0;
    unique case (n)
      4'h0: s = 4'hE;
      4'h1: s = 4'h4;
      4'h2: s = 4'hD;
      4'h3: s = 4'h1;
      4'h4: s = 4'h2;
      4'h5: s = 4'hF;
      4'h6: s = 4'hB;
      4'h7: s = 4'h8;
      4'h8: s = 4'h3;
      4'h9: s = 4'hA;
      4'hA: s = 4'h6;
      4'hB: s = 4'hC;
      4'hC: s = 4'h5;
      4'hD: s = 4'h9;
      4'hE: s = 4'h0;
      4'hF: s = 4'h7;
    endcase
    return s;
  endfunction

  // Multiply by x in GF(2^4) modulo x^4+x+1.
  function automatic logic [3:0] xtime(input logic [3:0] r);
    return {r[2:0], 1'b0} ^ (r[3] ? 4'h3 : 4'h0);
  endfunction

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    work_d  = work_q;
    t_d     = t_q;
    rcon_d  = rcon_q;
    rnum_d  = rnum_q;

    if (load_key_init) begin
      key_d   = key_in;
      work_d  = key_in;
      rnum_d  = 4'd0;
      rcon_d  = 4'd1;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_key_generation) begin
            // Saturated: just acknowledge, key and counter untouched.
            state_d = (rnum_q < RoundsN) ? StSub : StDone;
          end
        end
        StSub: begin
          t_d     = sbox(key_q[3:0]) ^ rcon_q;
          state_d = StW0;
        end
        StW0: begin
          work_d[15:12] = key_q[15:12] ^ t_q;
          state_d       = StW1;
        end
        StW1: begin
          work_d[11:8] = key_q[11:8] ^ work_q[15:12];
          state_d      = StW2;
        end
        StW2: begin
          work_d[7:4] = key_q[7:4] ^ work_q[11:8];
          state_d     = StW3;
        end
        StW3: begin
          // Last nibble goes straight to the published key so it updates in one step.
          work_d[3:0] = key_q[3:0] ^ work_q[7:4];
          key_d       = {work_q[15:4], key_q[3:0] ^ work_q[7:4]};
          rnum_d      = rnum_q + 4'd1;
          rcon_d      = xtime(rcon_q);
          state_d     = StDone;
        end
        StDone: begin
          if (!load_key_generation) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      key_q   <= 16'h0000;
      work_q  <= 16'h0000;
      t_q     <= 4'h0;
      rcon_q  <= 4'h1;
      rnum_q  <= 4'd0;
      done_q  <= 1'b0;
      final_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      work_q  <= work_d;
      t_q     <= t_d;
      rcon_q  <= rcon_d;
      rnum_q  <= rnum_d;
      // Flags are registered from next-state values so they line up with the key update.
      done_q  <= (state_d == StDone);
      final_q <= (rnum_d == RoundsN);
    end
  end

  assign round_key           = key_q;
  assign key_generation_done = done_q;
  assign final_round         = final_q;
  assign round_num           = rnum_q;

endmodule

// File: tb/tb_mini_aes_key_schedule.sv
// Bench for mini_aes_key_schedule: two instances (ROUNDS=2 and ROUNDS=4) share stimulus.
// Stimulus pushes expected results into per-instance queues; monitors pop on each rising done.
module tb_mini_aes_key_schedule;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [15:0] key_in = 16'h0000;
  logic        load_key_init = 1'b0;
  logic        load_key_generation = 1'b0;

  logic [15:0] rk0, rk1;
  logic        done0, done1, fin0, fin1;
  logic [3:0]  rn0, rn1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mini_aes_key_schedule #(.ROUNDS(2)) u_dut2 (
    .clk                 (clk),
    .nrst                (nrst),
    .key_in              (key_in),
    .load_key_init       (load_key_init),
    .load_key_generation (load_key_generation),
    .round_key           (rk0),
    .key_generation_done (done0),
    .final_round         (fin0),
    .round_num           (rn0)
  );

  mini_aes_key_schedule #(.ROUNDS(4)) u_dut4 (
    .clk                 (clk),
    .nrst                (nrst),
    .key_in              (key_in),
    .load_key_init       (load_key_init),
    .load_key_generation (load_key_generation),
    .round_key           (rk1),
    .key_generation_done (done1),
    .final_round         (fin1),
    .round_num           (rn1)
  );

  // ---------------- reference model ----------------
  localparam int SB[16] = '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7};

  typedef struct {
    int key;
    int rnum;
    int fin;
    int lat;
    int issue;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   m_key[2];
  int   m_rnum[2];
  int   m_rcon[2];

  function automatic int rounds_of(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  function automatic int model_next(input int key, input int rcon);
    int w[4];
    int n[4];
    for (int i = 0; i < 4; i++) w[i] = (key >> (12 - 4 * i)) & 15;
    n[0] = w[0] ^ SB[w[3]] ^ rcon;
    for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i - 1];
    return (n[0] << 12) | (n[1] << 8) | (n[2] << 4) | n[3];
  endfunction

  function automatic int gf_mul2(input int r);
    int v;
    v = r * 2;
    if (v > 15) v = v ^ 19;
    return v;
  endfunction

  task automatic model_reset(input int key);
    for (int d = 0; d < 2; d++) begin
      m_key[d]  = key;
      m_rnum[d] = 0;
      m_rcon[d] = 1;
    end
  endtask

  task automatic model_issue(input int iss);
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      if (m_rnum[d] < rounds_of(d)) begin
        m_key[d]  = model_next(m_key[d], m_rcon[d]);
        m_rcon[d] = gf_mul2(m_rcon[d]);
        m_rnum[d] = m_rnum[d] + 1;
        e.lat     = 6;
      end else begin
        e.lat = 1;
      end
      e.key   = m_key[d];
      e.rnum  = m_rnum[d];
      e.fin   = (m_rnum[d] == rounds_of(d)) ? 1 : 0;
      e.issue = iss;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic chk(input string name, input int d, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h (t=%0t)", name, d, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  task automatic mon_eval(input int d, input logic [15:0] rk, input logic [3:0] rn,
                          input logic fin);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d got key %0h want no done", d, rk);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk("round_key", d, int'(rk), e.key);
    chk("round_num", d, int'(rn), e.rnum);
    chk("final_round", d, int'(fin), e.fin);
    chk("done_latency", d, cyc - e.issue, e.lat);
  endtask

  initial begin
    logic p;
    p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done0 && !p) mon_eval(0, rk0, rn0, fin0);
      p = done0;
    end
  end

  initial begin
    logic p;
    p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done1 && !p) mon_eval(1, rk1, rn1, fin1);
      p = done1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_init(input logic [15:0] k);
    @(negedge clk);
    key_in        = k;
    load_key_init = 1'b1;
    @(negedge clk);
    load_key_init = 1'b0;
    model_reset(int'(k));
    chk("init_key", 0, int'(rk0), int'(k));
    chk("init_key", 1, int'(rk1), int'(k));
    chk("init_rnum", 0, int'(rn0), 0);
    chk("init_done", 1, int'(done1), 0);
  endtask

  task automatic wait_queues();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got pending %0d/%0d want 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic do_request(input int hold, input bit pulse);
    int n;
    @(negedge clk);
    load_key_generation = 1'b1;
    model_issue(cyc);
    if (pulse) begin
      @(negedge clk);
      load_key_generation = 1'b0;
      wait_queues();
      repeat (2) @(negedge clk);
      chk("pulse_done_low", 0, int'(done0), 0);
      chk("pulse_done_low", 1, int'(done1), 0);
    end else begin
      n = 0;
      while (!(done0 && done1) && n < 12) begin
        @(negedge clk);
        n++;
      end
      if (!(done0 && done1)) begin
        checks++;
        errors++;
        $display("FAIL req_timeout got done %0b%0b want 11", done0, done1);
      end
      wait_queues();
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_done", 0, int'(done0), 1);
        chk("hold_done", 1, int'(done1), 1);
        chk("hold_key", 0, int'(rk0), m_key[0]);
        chk("hold_key", 1, int'(rk1), m_key[1]);
      end
      load_key_generation = 1'b0;
      @(negedge clk);
      chk("drop_done", 0, int'(done0), 0);
      chk("drop_done", 1, int'(done1), 0);
    end
  endtask

  initial begin
    model_reset(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_key", 0, int'(rk0), 0);
    chk("rst_key", 1, int'(rk1), 0);
    chk("rst_done", 0, int'(done0), 0);
    chk("rst_final", 0, int'(fin0), 0);
    chk("rst_rnum", 1, int'(rn1), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Known-answer rounds from key C3F0.
    do_init(16'hC3F0);
    do_request(0, 1'b0);
    chk("k1", 0, int'(rk0), 16'h30FF);
    do_request(10, 1'b0);
    chk("k2", 0, int'(rk0), 16'h6696);
    chk("k2_final", 0, int'(fin0), 1);
    do_request(0, 1'b0);
    chk("k3", 1, int'(rk1), 16'h9F60);
    chk("k2_saturated", 0, int'(rk0), 16'h6696);
    chk("rnum_saturated", 0, int'(rn0), 2);
    do_request(2, 1'b0);
    chk("k4_final", 1, int'(fin1), 1);
    do_request(3, 1'b0);
    chk("rnum4_saturated", 1, int'(rn1), 4);

    // Init during W1 discards the round in flight.
    do_init(16'hC3F0);
    @(negedge clk);
    load_key_generation = 1'b1;
    repeat (3) @(negedge clk);
    key_in              = 16'hC3F0;
    load_key_init       = 1'b1;
    load_key_generation = 1'b0;
    @(negedge clk);
    load_key_init = 1'b0;
    model_reset(16'hC3F0);
    chk("abort_key", 0, int'(rk0), 16'hC3F0);
    chk("abort_rnum", 1, int'(rn1), 0);
    repeat (8) @(negedge clk);
    chk("abort_done", 0, int'(done0), 0);
    chk("abort_done", 1, int'(done1), 0);
    do_request(0, 1'b0);
    chk("after_abort", 0, int'(rk0), 16'h30FF);

    // One-cycle request pulse still completes the round.
    do_init(16'hC3F0);
    do_request(0, 1'b1);
    chk("pulse_key", 1, int'(rk1), 16'h30FF);

    // Asynchronous reset during W2.
    @(negedge clk);
    load_key_generation = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_key", 0, int'(rk0), 0);
    chk("arst_key", 1, int'(rk1), 0);
    chk("arst_rnum", 1, int'(rn1), 0);
    chk("arst_done", 0, int'(done0), 0);
    load_key_generation = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_reset(0);
    do_init(16'hC3F0);
    do_request(0, 1'b0);
    chk("post_rst_key", 1, int'(rk1), 16'h30FF);

    // Randomised mix of inits, held requests and pulses.
    for (int it = 0; it < 40; it++) begin
      int op;
      op = int'($urandom_range(0, 5));
      if (op == 0) do_init(16'($urandom));
      else if (op <= 3) do_request(int'($urandom_range(0, 3)), 1'b0);
      else do_request(0, 1'b1);
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
